// File: rtl/cmplx_mult_arbiter.sv
// Round-robin arbiter that shares one pipelined complex multiplier between two
// requesters, tagging each issued operation so its result returns to its issuer.
module cmplx_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*WIDTH-1:0]   req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*WIDTH-1:0]   req1_data,
    output logic                 mult_valid_in,
    output logic [4*WIDTH-1:0]   mult_data,
    input  logic                 mult_valid_out,
    input  logic [2*WIDTH-1:0]   mult_res,
    output logic                 res0_valid,
    output logic [2*WIDTH-1:0]   res0_data,
    output logic                 res1_valid,
    output logic [2*WIDTH-1:0]   res1_data,
    output logic                 err
);

    localparam int CW = $clog2(LATENCY + 1);

    logic               last_grant;
    logic               grant0;
    logic               grant1;
    logic               issue_id;
    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_id;
    logic [CW-1:0]      mask_cnt;
    logic               mask;
    logic               exp_valid;
    logic               exp_id;

    // Handshake: a request transfers in any cycle where reqN_valid && reqN_ready;
    // ready depends on valid, so dropping valid cancels the grant that cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign exp_valid = tag_valid[LATENCY-1];
    assign exp_id    = tag_id[LATENCY-1];
    assign mask      = (mask_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= 1'b1;
            mult_valid_in <= 1'b0;
            mult_data     <= '0;
            issue_id      <= 1'b0;
            tag_valid     <= '0;
            tag_id        <= '0;
            mask_cnt      <= CW'(LATENCY);
            res0_valid    <= 1'b0;
            res1_valid    <= 1'b0;
            res0_data     <= '0;
            res1_data     <= '0;
            err           <= 1'b0;
        end else begin
            mult_valid_in <= grant0 || grant1;
            if (grant0) begin
                last_grant <= 1'b0;
                mult_data  <= req0_data;
                issue_id   <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
                mult_data  <= req1_data;
                issue_id   <= 1'b1;
            end

            // Tag stage 0 follows the issue register, so the last stage lines up
            // with the cycle the multiplier should present the matching result.
            tag_valid[0] <= mult_valid_in;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end

            if (mask) begin
                mask_cnt <= mask_cnt - CW'(1);
            end

            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            if (!mask && exp_valid && mult_valid_out) begin
                if (exp_id) begin
                    res1_valid <= 1'b1;
                    res1_data  <= mult_res;
                end else begin
                    res0_valid <= 1'b1;
                    res0_data  <= mult_res;
                end
            end

            // After reset the multiplier may still drain dropped work; ignore it.
            if (!mask && (mult_valid_out != exp_valid)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cmplx_mult_arbiter.md
# cmplx_mult_arbiter

Two-requester round-robin arbiter that shares one pipelined complex multiplier between two independent clients. Each cycle it grants at most one request and issues its operands to the multiplier. It tracks each in-flight operation with a tag pipeline so it can route the result back to the requester that issued it. A sticky error flag reports any multiplier output that arrives when no result is expected.

## Interface
Parameters:
- WIDTH, 8: bits per real or imaginary component, two's complement.
- LATENCY, 3: fixed multiplier pipeline depth in cycles, from `mult_valid_in` to `mult_valid_out`. Must be ≥1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N has an operand set pending.
- req0_ready / req1_ready  out  1  grant to requester N; the transfer happens on any cycle where valid && ready.
- req0_data / req1_data  in  4*WIDTH  packed operands {re_a, im_a, re_q, im_q}, MSB first.
- mult_valid_in  out  1  operands on `mult_data` are valid this cycle.
- mult_data  out  4*WIDTH  operands to the multiplier, same packing as the request data.
- mult_valid_out  in  1  multiplier result valid.
- mult_res  in  2*WIDTH  multiplier result {re, im}; the multiplier defines the truncation.
- res0_valid / res1_valid  out  1  single-cycle result strobe to requester N. There is no backpressure on results.
- res0_data / res1_data  out  2*WIDTH  result {re, im}; holds its last value when the strobe is low.
- err  out  1  sticky error: unexpected or missing multiplier output.

## Operation
- **Grant logic (combinational):**
  - If exactly one request is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - `reqN_ready` is low whenever `reqN_valid` is low or `reset` is high.
  - The arbiter never grants both requesters in the same cycle.
- **Priority pointer:**
  - `last_grant` updates only on a completed transfer.
  - Reset sets `last_grant` = 1, so requester 0 wins the first contention.
- **Issue stage (registered):**
  - On a transfer, the next cycle has `mult_valid_in`=1 and `mult_data` equal to the granted `reqN_data`.
  - `mult_data` holds its value while idle.
  - Issue rate is one operation per cycle, with no bubbles under continuous requests.
- **Tag pipeline:**
  - A shift register of depth LATENCY carries {valid, requester id}, aligned with `mult_valid_in`.
  - Its output is the expected {valid, id} in the cycle `mult_valid_out` should arrive.
- **Result routing (registered):**
  - When the expected valid and `mult_valid_out` are both 1, the next cycle has `res<id>_valid`=1 and `res<id>_data` = `mult_res`.
  - The other requester's strobe stays 0.
- **Error detection:**
  - `err` is set when `mult_valid_out` ≠ expected valid.
  - Once set, `err` stays set until reset.
  - On a mismatch, no result strobe is generated.
- **Post-reset mask:**
  - A down-counter loaded with LATENCY on reset masks error checking for LATENCY cycles after reset deasserts.
  - During the mask, `mult_valid_out` is ignored and produces no result.
- **Reset (synchronous):**
  - Clears the tag pipeline, all valid outputs, `err`, `mult_data`, `res*_data`, and the issue registers.
  - Operations in flight at reset are dropped; no result is ever delivered for them.

## Timing
- Reset values: `req*_ready`=0, `mult_valid_in`=0, `mult_data`=0, `res*_valid`=0, `res*_data`=0, `err`=0.
- A transfer in cycle T produces:
  - `mult_valid_in` in cycle T+1;
  - expected `mult_valid_out` in cycle T+1+LATENCY;
  - `resN_valid` in cycle T+2+LATENCY.
- Total request-to-result latency is LATENCY+2 cycles.
- Results return in issue order; throughput is one result per cycle.
- Boundary conditions:
  - A `reqN_valid` drop in the same cycle as the grant: the transfer does not happen and the pointer does not change.
  - A transfer in the cycle reset asserts is discarded.
  - With a single requester valid every cycle, that requester gets ready=1 every cycle; fairness only applies under contention.

## Test plan
- **Single request.** WIDTH=8, LATENCY=3. Drive req0 with a=3+2j, q=1+4j; the model multiplier returns -5+14j.
  - Expect `mult_valid_in` at T+1.
  - Expect `res0_valid` for exactly one cycle at T+5, with `res0_data`={8'hFB, 8'h0E}.
  - `res1_valid` stays 0 and `err`=0.
- **Contention after reset.** Hold both requests valid for 6 cycles.
  - Grants go 0,1,0,1,0,1.
  - Results arrive on consecutive cycles with alternating strobes, each matching its operands.
- **Single-requester streaming.** Hold only req1 valid for 4 cycles with distinct operands.
  - `req1_ready`=1 on all 4 cycles.
  - 4 consecutive `res1_valid` strobes arrive in order; `res0_valid` never rises.
- **Reset mid-flight.** Issue 2 requests, then assert reset for 1 cycle at T+2 while the model multiplier still emits both results.
  - No `res*_valid` follows.
  - `err` stays 0 through the post-reset mask.
- **Error injection.** Force `mult_valid_out`=1 for one cycle while idle (outside the mask).
  - `err` rises the next cycle and stays 1 through later traffic.
  - `err` clears only on reset.
  - No spurious result strobe occurs.
